// File: rtl/updown_count.sv
// Synchronous WIDTH-bit up/down counter with enable.
// The count register drives out_data directly, so no input reaches the output combinationally.
module updown_count #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;

    // Unsigned modulo-2^WIDTH stepping; wrap in both directions is intentional.
    always_comb begin
        w_count_next = r_count;
        if (en) begin
            if (up) begin
                w_count_next = r_count + WIDTH'(1);
            end else begin
                w_count_next = r_count - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign out_data = r_count;

endmodule

// File: tb/tb_updown_count.sv
// Directed self-checking bench for updown_count (WIDTH = 16).
// Inputs change on the falling edge; out_data is sampled on the falling edge after each step.
module tb_updown_count;

    localparam int unsigned W = 16;

    logic         clk;
    logic         reset;
    logic         en;
    logic         up;
    logic [W-1:0] out_data;

    int unsigned n_checks;
    int unsigned n_errors;

    updown_count #(
        .WIDTH(W)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .out_data (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    // Apply n rising edges, returning on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        en       = 1'b0;
        up       = 1'b0;
        @(negedge clk);

        step(1);
        check("reset_en0", out_data, 16'h0000);
        en = 1'b1;
        up = 1'b1;
        step(1);
        check("reset_prio", out_data, 16'h0000);

        reset = 1'b0;
        step(50);
        check("up50", out_data, 16'd50);
        step(1);
        check("up51", out_data, 16'd51);

        up = 1'b0;
        step(26);
        check("down25", out_data, 16'd25);

        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            up = ~up;
            step(1);
        end
        check("hold10", out_data, 16'd25);

        // A change on en must not reach out_data before the next edge.
        en = 1'b1;
        up = 1'b1;
        #1;
        check("no_comb_path", out_data, 16'd25);
        step(1);
        check("reenable", out_data, 16'd26);

        reset = 1'b1;
        step(1);
        check("reset2", out_data, 16'h0000);
        reset = 1'b0;
        up    = 1'b0;
        step(1);
        check("wrap_down", out_data, 16'hFFFF);
        up = 1'b1;
        step(1);
        check("wrap_up_ffff", out_data, 16'h0000);

        up = 1'b0;
        step(2);
        check("to_fffe", out_data, 16'hFFFE);
        up = 1'b1;
        step(1);
        check("fffe_inc", out_data, 16'hFFFF);
        step(1);
        check("ffff_inc", out_data, 16'h0000);

        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(37);
        check("at37", out_data, 16'd37);
        reset = 1'b1;
        step(1);
        check("reset_mid", out_data, 16'h0000);
        reset = 1'b0;
        step(1);
        check("resume1", out_data, 16'd1);

        // Direction flip takes effect on the very next edge.
        step(1);
        check("dir_inc", out_data, 16'd2);
        up = 1'b0;
        step(1);
        check("dir_dec", out_data, 16'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/updown_count.md
Name: updown_count

Overview:
- Synchronous binary up/down counter with enable.
- Holds a WIDTH-bit count value and steps it by one per clock edge when enabled. The `up` input selects the direction.
- General-purpose block for event counting and timers. The count is presented directly as a registered output.

Parameters:
- WIDTH, 16, bit width of the counter and of out_data.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset; clears the counter.
- en  input  1  count enable; when 0 the counter holds.
- up  input  1  direction: 1 = increment, 0 = decrement.
- out_data  output  WIDTH  current count value, driven directly from the counter register.

Behaviour:
- Single clock domain. All inputs are sampled on the rising edge of clk.
- Reset is synchronous and active-high. If reset = 1 at a rising edge, the counter becomes 0 at that edge, regardless of en and up.
- Reset value: out_data = 0.
- Reset has priority over en and up.
- Before the first reset, the counter value is undefined. Benches must apply reset first.
- Update rule, evaluated at each rising edge, first match wins:
  - reset = 1: count <= 0.
  - en = 0: count <= count (hold).
  - en = 1, up = 1: count <= count + 1.
  - en = 1, up = 0: count <= count - 1.
- Latency: out_data reflects a step at the same edge that sampled en/up.
  - A change to en or up takes effect at the next rising edge after the change.
  - There is no combinational path from any input to out_data.
- Arithmetic is unsigned modulo 2^WIDTH:
  - Increment at 2^WIDTH-1 (0xFFFF for WIDTH=16) wraps to 0.
  - Decrement at 0 wraps to 2^WIDTH-1.
  - No saturation, no overflow flag.
- Direction changes take effect at the next edge with no idle cycle. Example: up toggles 1→0 between edges N and N+1; edge N increments and edge N+1 decrements.
- Reset mid-count clears to 0 at the sampled edge. Counting resumes from 0 on the first edge where reset = 0 and en = 1.
- en deasserted for any number of cycles leaves out_data frozen.
- The counter register is the only state; out_data is the register output.

Test Plan:
- Reset: reset=1 for one edge with en=0 → out_data = 0 after that edge. Also reset=1 with en=1, up=1 → out_data stays 0.
- Count up: after reset, en=1, up=1 for 50 edges → out_data = 50. One more edge → 51.
- Count down: from 51, set up=0 and apply 26 edges with en=1 → out_data = 25.
- Hold: from 25, en=0 for 10 edges with up toggling each edge → out_data remains 25. Re-enable with up=1 for 1 edge → 26.
- Wrap-around:
  - Reset, then en=1, up=0 for 1 edge → out_data = 0xFFFF. Then up=1 for 1 edge → 0.
  - Separately, count up from 0xFFFE for 2 edges → 0xFFFF, then 0x0000.
- Reset mid-operation: counting up at value 37, assert reset for one edge with en=1 → out_data = 0. Deassert reset with up=1 → next edge 1.
